gp_regfile_sb: RTL and testbench

GP_REGFILE_SB -- requirements
Module: gp_regfile_sb

---
 rtl/gp_regfile_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/gp_regfile_sb.sv | 74 +++++++
 tb/tb_gp_regfile_sb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/gp_regfile_pkg.sv
// Shared defaults and the register index type for the general-purpose register file.
package gp_regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with a registered population counter; x0 is never busy.
module rf_scoreboard
  import gp_regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_alloc_valid,
  input  logic [AW-1:0]    i_alloc_addr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic             i_flush,
  output logic [NREGS-1:0] o_busy,
  output logic [AW:0]      o_busy_cnt
);
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_cnt;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_set, w_clr, w_inc, w_dec;

  // Alloc is applied after the clear so a same-index producer keeps the bit set.
  always_comb begin
    w_set      = i_alloc_valid && (i_alloc_addr != '0);
    w_clr      = i_we && (i_wr_addr != '0);
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[i_wr_addr] = 1'b0;
    if (w_set) w_busy_nxt[i_alloc_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_inc = w_set && !r_busy[i_alloc_addr];
    w_dec = w_clr && r_busy[i_wr_addr] && !(w_set && (i_alloc_addr == i_wr_addr));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;
endmodule

// File: rtl/gp_regfile_sb.sv
// Register file with NRD combinational read ports and a producer scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module gp_regfile_sb
  import gp_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [AW:0]      w_cnt;
  logic             w_wr_en;

  assign w_wr_en = we && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alloc_valid(alloc_valid),
    .i_alloc_addr (alloc_addr),
    .i_we         (we),
    .i_wr_addr    (wr_addr),
    .i_flush      (flush),
    .o_busy       (w_busy),
    .o_busy_cnt   (w_cnt)
  );

  // Outputs are held at zero while reset is asserted, not only after the edge.
  assign busy_cnt = rst ? '0 : w_cnt;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_stored, w_data;
    logic            w_bsy;

    assign w_ra     = rd_addr[p*AW +: AW];
    assign w_stored = (w_ra == '0) ? '0 : r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit  = w_wr_en && (w_ra == wr_addr);
    assign w_data = w_hit ? wr_data : w_stored;
    // A same-index alloc means a newer producer is in flight, so keep the registered flag.
    assign w_bsy  = (w_hit && !(alloc_valid && (alloc_addr == wr_addr))) ? 1'b0 : w_busy[w_ra];
`else
    assign w_data = w_stored;
    assign w_bsy  = w_busy[w_ra];
`endif
    assign rd_data[p*XLEN +: XLEN] = rst ? '0 : w_data;
    assign rd_busy[p]              = rst ? 1'b0 : w_bsy;
  end
endmodule

// File: tb/tb_gp_regfile_sb.sv
// Directed self-checking bench for gp_regfile_sb (default parameters, both bypass builds).
module tb_gp_regfile_sb;
  logic        clk = 1'b0;
  logic        rst, we, alloc_valid, flush;
  logic [4:0]  wr_addr, alloc_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_cnt;
  logic [31:0] rd0, rd1;
  int n_chk = 0;
  int n_fail = 0;

  assign rd0 = rd_data[31:0];
  assign rd1 = rd_data[63:32];

  gp_regfile_sb dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 0; wr_addr = 0; wr_data = 0; alloc_valid = 0; alloc_addr = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rd_addr = {5'd5, 5'd5};
    step(); step();
    rst = 0;
    we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; alloc_valid = 1; alloc_addr = 12;
    step(); idle(); #1;
    n_chk++; if (rd0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_prewrite got %h exp %h", rd0, 32'hDEADBEEF); end
    n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL rst_precnt got %0d exp 1", busy_cnt); end
    // reset dominates write/alloc/flush in the same cycle
    rst = 1; we = 1; wr_addr = 5; wr_data = 32'h1234; alloc_valid = 1; alloc_addr = 6; flush = 1; #1;
    n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_during_rd got %h exp 0", rd_data); end
    n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_during_cnt got %0d exp 0", busy_cnt); end
    step(); rst = 0; idle(); rd_addr = {5'd6, 5'd5}; #1;
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rst_x5 got %h exp 0", rd0); end
    n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", busy_cnt); end
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL rst_busy got %b exp 00", rd_busy); end
    rd_addr = {5'd12, 5'd12}; #1;
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL rst_busy12 got %b exp 00", rd_busy); end
  endtask

  task automatic test_x0();
    we = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; alloc_valid = 1; alloc_addr = 0; rd_addr = {5'd0, 5'd0}; #1;
    n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL x0_same got %h exp 0", rd_data); end
    step(); idle(); #1;
    n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL x0_rd got %h exp 0", rd_data); end
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy got %b exp 00", rd_busy); end
    n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL x0_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_scoreboard();
    alloc_valid = 1; alloc_addr = 3; step();
    alloc_addr = 7; step(); idle(); rd_addr = {5'd7, 5'd3}; #1;
    n_chk++; if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL sb_cnt2 got %0d exp 2", busy_cnt); end
    n_chk++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL sb_busy got %b exp 11", rd_busy); end
    we = 1; wr_addr = 3; wr_data = 32'h12; step(); idle(); #1;
    n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt1 got %0d exp 1", busy_cnt); end
    n_chk++; if (rd0 !== 32'h12) begin n_fail++; $display("FAIL sb_x3 got %h exp 12", rd0); end
    n_chk++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL sb_busy2 got %b exp 10", rd_busy); end
    alloc_valid = 1; alloc_addr = 7; step(); idle(); #1;
    n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_realloc got %0d exp 1", busy_cnt); end
    we = 1; wr_addr = 7; wr_data = 32'h77; step(); idle(); #1;
    n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_cnt0 got %0d exp 0", busy_cnt); end
    n_chk++; if (rd1 !== 32'h77) begin n_fail++; $display("FAIL sb_x7 got %h exp 77", rd1); end
  endtask

  task automatic test_collision();
    alloc_valid = 1; alloc_addr = 9; step();
    we = 1; wr_addr = 9; wr_data = 32'h55; step(); idle(); rd_addr = {5'd10, 5'd9}; #1;
    n_chk++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL col_busy got %b exp 1", rd_busy[0]); end
    n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL col_cnt got %0d exp 1", busy_cnt); end
    n_chk++; if (rd0 !== 32'h55) begin n_fail++; $display("FAIL col_data got %h exp 55", rd0); end
    // alloc and write to different indices in the same cycle: net count unchanged
    alloc_valid = 1; alloc_addr = 10; we = 1; wr_addr = 9; wr_data = 32'h56; step(); idle(); #1;
    n_chk++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL col_swap got %b exp 10", rd_busy); end
    n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL col_swapcnt got %0d exp 1", busy_cnt); end
    we = 1; wr_addr = 10; wr_data = 32'h0; step(); idle();
  endtask

  task automatic test_flush();
    alloc_valid = 1; alloc_addr = 1; step();
    alloc_addr = 2; step();
    alloc_addr = 4; step(); idle(); #1;
    n_chk++; if (busy_cnt !== 6'd3) begin n_fail++; $display("FAIL fl_pre got %0d exp 3", busy_cnt); end
    flush = 1; alloc_valid = 1; alloc_addr = 6; we = 1; wr_addr = 11; wr_data = 32'h77; step(); idle();
    rd_addr = {5'd1, 5'd6}; #1;
    n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL fl_cnt got %0d exp 0", busy_cnt); end
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL fl_busy got %b exp 00", rd_busy); end
    rd_addr = {5'd4, 5'd11}; #1;
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL fl_busy4 got %b exp 00", rd_busy); end
    n_chk++; if (rd0 !== 32'h77) begin n_fail++; $display("FAIL fl_data got %h exp 77", rd0); end
  endtask

  task automatic test_bypass();
    we = 1; wr_addr = 8; wr_data = 32'h1; step();
    idle(); alloc_valid = 1; alloc_addr = 8; step(); idle();
    we = 1; wr_addr = 8; wr_data = 32'hA5A5; rd_addr = {5'd8, 5'd8}; #1;
`ifdef REGFILE_BYPASS_EN
    n_chk++; if (rd_data !== {32'hA5A5, 32'hA5A5}) begin n_fail++; $display("FAIL byp_data got %h exp a5a5 x2", rd_data); end
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL byp_busy got %b exp 00", rd_busy); end
`else
    n_chk++; if (rd_data !== {32'h1, 32'h1}) begin n_fail++; $display("FAIL byp_data got %h exp 1 x2", rd_data); end
    n_chk++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL byp_busy got %b exp 11", rd_busy); end
`endif
    step(); idle(); #1;
    n_chk++; if (rd_data !== {32'hA5A5, 32'hA5A5}) begin n_fail++; $display("FAIL byp_after got %h exp a5a5 x2", rd_data); end
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL byp_after_busy got %b exp 00", rd_busy); end
    alloc_valid = 1; alloc_addr = 8; step();
    we = 1; wr_addr = 8; wr_data = 32'hBEEF; #1;
`ifdef REGFILE_BYPASS_EN
    n_chk++; if (rd0 !== 32'hBEEF) begin n_fail++; $display("FAIL byp_alloc_data got %h exp beef", rd0); end
`else
    n_chk++; if (rd0 !== 32'hA5A5) begin n_fail++; $display("FAIL byp_alloc_data got %h exp a5a5", rd0); end
`endif
    n_chk++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL byp_alloc_busy got %b exp 11", rd_busy); end
    step(); idle(); flush = 1; step(); idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      alloc_valid = 1; alloc_addr = 5'(i); we = 1; wr_addr = 5'(i); wr_data = 32'(i * 32'h01010101); step();
    end
    idle(); alloc_valid = 1; alloc_addr = 31; step(); idle(); #1;
    n_chk++; if (busy_cnt !== 6'd31) begin n_fail++; $display("FAIL b2b_full got %0d exp 31", busy_cnt); end
    rd_addr = {5'd31, 5'd17}; #1;
    n_chk++; if (rd_data !== {32'h1F1F1F1F, 32'h11111111}) begin n_fail++; $display("FAIL b2b_data got %h exp 1f1f1f1f11111111", rd_data); end
    we = 1; wr_addr = 17; wr_data = 32'h0; step();
    wr_addr = 31; step(); idle(); #1;
    n_chk++; if (busy_cnt !== 6'd29) begin n_fail++; $display("FAIL b2b_drain got %0d exp 29", busy_cnt); end
    n_chk++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL b2b_busy got %b exp 00", rd_busy); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_flush();
    test_bypass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
